// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seg_scan_driver block: converter FSM encoding,
// the largest displayable value for a digit count, and nibble/anode constants.
package seg_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_e;

  localparam int         BCD_W     = 4;
  localparam logic [7:0] ANODE_OFF = 8'hFF;

  // 10^digits - 1; 64-bit so that eight digits never overflow the arithmetic.
  function automatic longint unsigned max_value(input int digits);
    longint unsigned p;
    p = 64'd1;
    for (int i = 0; i < digits; i++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

  // Double-dabble correction applied to a BCD nibble before each left shift.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/seg_scan_driver_bin2bcd.sv
// bin2bcd_seq: sequential double-dabble converter. LOAD captures VALUE (clamped to
// the display maximum), BIN_W shift/add-3 cycles follow, then a one-cycle DONE.
module bin2bcd_seq
  import seg_scan_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_load,
  input  logic [BIN_W-1:0]          i_value,
  output logic                      o_busy,
  output logic                      o_ovf,
  output logic [DIGITS*BCD_W-1:0]   o_bcd,
  output logic                      o_done
);

  localparam int              BCD_TOT = DIGITS * BCD_W;
  localparam int              CNT_W   = $clog2(BIN_W + 1);
  localparam longint unsigned MAX_L   = max_value(DIGITS);

  conv_state_e          r_state;
  conv_state_e          w_state_nxt;
  logic [BIN_W-1:0]     r_bin;
  logic [BCD_TOT-1:0]   r_bcd;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_ovf_pend;
  logic                 r_ovf;

  logic                 w_take;
  logic                 w_over;
  logic [BIN_W-1:0]     w_cap;
  logic [BCD_TOT-1:0]   w_adj;
  logic [BCD_TOT-1:0]   w_bcd_shift;

  always_comb begin
    w_over = (64'(i_value) > MAX_L);
    w_cap  = w_over ? BIN_W'(MAX_L) : i_value;
  end

  always_comb begin
    w_adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      w_adj[i*BCD_W +: BCD_W] = add3(r_bcd[i*BCD_W +: BCD_W]);
    end
    w_bcd_shift = {w_adj[BCD_TOT-2:0], r_bin[BIN_W-1]};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_load) begin
          w_take      = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        o_busy = 1'b1;
        if (r_cnt == CNT_W'(BIN_W - 1)) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        o_busy      = 1'b1;
        o_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: capture on accepted LOAD, then one shift per SHIFT cycle.
  always_ff @(posedge i_clk) begin
    if (w_take) begin
      r_bin      <= w_cap;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= w_over;
    end else if (r_state == ST_SHIFT) begin
      r_bin <= r_bin << 1;
      r_bcd <= w_bcd_shift;
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ovf <= 1'b0;
    end else if (r_state == ST_DONE) begin
      r_ovf <= r_ovf_pend;
    end
  end

  assign o_ovf = r_ovf;
  assign o_bcd = r_bcd;

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: binary value -> BCD display register -> multiplexed digit scan.
// Optional LEADING_ZERO_BLANK_EN darkens digits above the most significant non-zero one.
module seg_scan_driver
  import seg_scan_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int BIN_W       = 14,
  parameter int REFRESH_DIV = 50000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic [BIN_W-1:0]   i_value,
  output logic               o_busy,
  output logic               o_ovf,
  output logic [3:0]         o_digit,
  output logic [DIGITS-1:0]  o_anode
);

  localparam int BCD_TOT = DIGITS * BCD_W;
  localparam int PRE_W   = $clog2(REFRESH_DIV);
  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [BCD_TOT-1:0]  w_bcd;
  logic                w_done;
  logic [BCD_TOT-1:0]  r_disp;
  logic [PRE_W-1:0]    r_pre;
  logic [IDX_W-1:0]    r_idx;
  logic [3:0]          r_digit;
  logic [DIGITS-1:0]   r_anode;

  logic [BCD_W-1:0]    w_cur_digit;
  logic [DIGITS-1:0]   w_sel;
  logic [DIGITS-1:0]   w_blank;
  logic [DIGITS-1:0]   w_anode_nxt;

  bin2bcd_seq #(
    .DIGITS (DIGITS),
    .BIN_W  (BIN_W)
  ) u_conv (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (i_load),
    .i_value (i_value),
    .o_busy  (o_busy),
    .o_ovf   (o_ovf),
    .o_bcd   (w_bcd),
    .o_done  (w_done)
  );

  // Whole display replaced in one edge so the scan never mixes old and new digits.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_disp <= '0;
    end else if (w_done) begin
      r_disp <= w_bcd;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pre <= '0;
      r_idx <= '0;
    end else if (r_pre == PRE_W'(REFRESH_DIV - 1)) begin
      r_pre <= '0;
      r_idx <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
    end else begin
      r_pre <= r_pre + PRE_W'(1);
    end
  end

  always_comb begin
    w_cur_digit = r_disp[r_idx*BCD_W +: BCD_W];
    w_sel       = DIGITS'(1) << r_idx;
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic w_upper_zero;
  // Digit i is dark when it and every digit above it are zero; digit0 always lit.
  always_comb begin
    w_blank      = '0;
    w_upper_zero = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      w_upper_zero = w_upper_zero & (r_disp[i*BCD_W +: BCD_W] == '0);
      w_blank[i]   = w_upper_zero;
    end
  end
`else
  assign w_blank = '0;
`endif

  assign w_anode_nxt = ~(w_sel & ~w_blank);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_digit <= '0;
      r_anode <= ANODE_OFF[DIGITS-1:0];
    end else begin
      r_digit <= w_cur_digit;
      r_anode <= w_anode_nxt;
    end
  end

  assign o_digit = r_digit;
  assign o_anode = r_anode;

endmodule
